serie_paralelo_rx: RTL and testbench

- Receive-side serial-to-parallel converter for the PHY link, running on `clk_8f` only.
- Takes the MSB-first serial stream from the transmit serializer and finds byte alignment by hunting for the 0xBC comma/idle byte.
- Declares the link active after `BC_COUNT` consecutive aligned commas.
- Then emits one parallel byte per 8 bit-times, with a strobe and a valid flag that marks non-idle data.

---
 rtl/serie_paralelo_rx.sv | 117 +++++++++++
 tb/tb_serie_paralelo_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serie_paralelo_rx.sv
// Receive-side serial-to-parallel converter: finds byte alignment on the COMMA idle byte,
// locks after BC_COUNT aligned commas, then emits one registered byte every 8 clk_8f cycles.
module serie_paralelo_rx #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_inS,
  output logic [7:0] data_outP,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  typedef enum logic [1:0] {
    HUNT,
    ALIGN,
    ACTIVE
  } state_t;

  localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

  state_t     state, state_nxt;
  logic [7:0] sr;
  logic [7:0] nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [3:0] bc_cnt, bc_cnt_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt, strobe_nxt, active_nxt;
  logic       is_comma, boundary;

  // Decisions look at the byte including the bit arriving this cycle, so no bit is lost.
  assign nxt      = {sr[6:0], data_inS};
  assign is_comma = (nxt == COMMA);
  assign boundary = (bit_cnt == 3'd7);

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state       <= HUNT;
      sr          <= 8'h00;
      bit_cnt     <= 3'd0;
      bc_cnt      <= 4'd0;
      data_outP   <= 8'h00;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_nxt;
      sr          <= nxt;
      bit_cnt     <= bit_cnt_nxt;
      bc_cnt      <= bc_cnt_nxt;
      data_outP   <= data_nxt;
      valid_out   <= valid_nxt;
      byte_strobe <= strobe_nxt;
      active      <= active_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bc_cnt_nxt  = bc_cnt;
    data_nxt    = data_outP;
    valid_nxt   = 1'b0;
    strobe_nxt  = 1'b0;
    active_nxt  = active;

    case (state)
      // Bit-granular search; the comma just found counts as the first one.
      HUNT: begin
        if (is_comma) begin
          bit_cnt_nxt = 3'd0;
          bc_cnt_nxt  = 4'd1;
          if (BC_TARGET == 4'd1) begin
            state_nxt  = ACTIVE;
            active_nxt = 1'b1;
          end else begin
            state_nxt = ALIGN;
          end
        end
      end

      ALIGN: begin
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (boundary) begin
          strobe_nxt = 1'b1;
          if (is_comma && (bc_cnt + 4'd1 == BC_TARGET)) begin
            bc_cnt_nxt = bc_cnt + 4'd1;
            state_nxt  = ACTIVE;
            active_nxt = 1'b1;
          end else if (is_comma) begin
            bc_cnt_nxt = bc_cnt + 4'd1;
          end else begin
            bc_cnt_nxt = 4'd0;
            state_nxt  = HUNT;
          end
        end
      end

      // Locked for good: only reset leaves this state.
      ACTIVE: begin
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (boundary) begin
          data_nxt   = nxt;
          strobe_nxt = 1'b1;
          valid_nxt  = !is_comma;
        end
      end

      default: begin
        state_nxt = HUNT;
      end
    endcase
  end

endmodule

// File: tb/tb_serie_paralelo_rx.sv
// Bench for serie_paralelo_rx: directed link scenarios plus random traffic, every cycle
// compared against a bit-stream reference model of the receiver.
module tb_serie_paralelo_rx;

  localparam logic [7:0] COMMA    = 8'hBC;
  localparam int         BC_COUNT = 4;

  logic       clk_8f = 1'b0;
  logic       reset = 1'b1;
  logic       data_inS = 1'b0;
  logic [7:0] data_outP;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  serie_paralelo_rx #(.COMMA(COMMA), .BC_COUNT(BC_COUNT)) dut (
    .clk_8f      (clk_8f),
    .reset       (reset),
    .data_inS    (data_inS),
    .data_outP   (data_outP),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  always #5 clk_8f = ~clk_8f;

  int errors = 0;
  int checks = 0;
  int seg_cycle;
  int act_rise;
  int strobe_cyc[$];
  logic [7:0] dut_q[$];
  logic [7:0] model_q[$];

  // Reference model: mode 0 = searching, 1 = counting commas, 2 = locked
  int m_win, m_mode, m_since, m_commas;
  int m_data;
  bit m_valid, m_strobe, m_active;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic b, input logic r);
    if (r) begin
      m_win = 0; m_mode = 0; m_since = 0; m_commas = 0;
      m_data = 0; m_valid = 0; m_strobe = 0; m_active = 0;
    end else begin
      m_win    = (m_win * 2 + int'(b)) % 256;
      m_strobe = 0;
      m_valid  = 0;
      if (m_mode == 0) begin
        if (m_win == int'(COMMA)) begin
          m_since  = 0;
          m_commas = 1;
          if (m_commas == BC_COUNT) begin m_mode = 2; m_active = 1; end
          else m_mode = 1;
        end
      end else begin
        m_since++;
        if (m_since % 8 == 0) begin
          m_strobe = 1;
          if (m_mode == 1) begin
            if (m_win == int'(COMMA)) begin
              m_commas++;
              if (m_commas == BC_COUNT) begin m_mode = 2; m_active = 1; end
            end else begin
              m_mode = 0;
              m_commas = 0;
            end
          end else begin
            m_data  = m_win;
            m_valid = (m_win != int'(COMMA));
            if (m_valid) model_q.push_back(8'(m_win));
          end
        end
      end
    end
  endtask

  task automatic check_output();
    check_eq("data_outP", 32'(data_outP), 32'(m_data));
    check_eq("valid_out", 32'(valid_out), 32'(m_valid));
    check_eq("byte_strobe", 32'(byte_strobe), 32'(m_strobe));
    check_eq("active", 32'(active), 32'(m_active));
    if (byte_strobe) strobe_cyc.push_back(seg_cycle);
    if (valid_out) dut_q.push_back(data_outP);
    if (active && act_rise < 0) act_rise = seg_cycle;
  endtask

  task automatic apply_stimulus(input logic b, input logic r);
    data_inS = b;
    reset    = r;
    @(posedge clk_8f);
    model_step(b, r);
    seg_cycle++;
    #1;
    check_output();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) apply_stimulus(v[i], 1'b0);
  endtask

  task automatic start_segment();
    seg_cycle = 0;
    act_rise  = -1;
    strobe_cyc.delete();
    dut_q.delete();
    model_q.delete();
  endtask

  task automatic compare_queues(input string tag);
    check_eq({tag, "_count"}, 32'(dut_q.size()), 32'(model_q.size()));
    for (int i = 0; i < model_q.size(); i++)
      check_eq({tag, "_byte"}, 32'(dut_q[i]), 32'(model_q[i]));
  endtask

  initial begin
    logic [7:0] rb;
    int n;
    model_step(1'b0, 1'b1);
    start_segment();

    $display("[TB] reset hold with random serial data");
    for (int i = 0; i < 5; i++) apply_stimulus(1'($urandom_range(0, 1)), 1'b1);
    check_eq("reset_data", 32'(data_outP), 32'h00);
    check_eq("reset_active", 32'(active), 32'h0);

    $display("[TB] lock and data");
    start_segment();
    repeat (4) send_byte(COMMA);
    send_byte(8'h5A);
    send_byte(8'h3C);
    send_byte(COMMA);
    check_eq("lock_active_rise", 32'(act_rise), 32'd32);
    check_eq("lock_valid_count", 32'(dut_q.size()), 32'd2);
    check_eq("lock_byte0", 32'(dut_q[0]), 32'h5A);
    check_eq("lock_byte1", 32'(dut_q[1]), 32'h3C);
    check_eq("lock_last_data", 32'(data_outP), 32'hBC);
    check_eq("lock_strobe_count", 32'(strobe_cyc.size()), 32'd6);
    for (int i = 1; i < strobe_cyc.size(); i++)
      check_eq("lock_strobe_gap", 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'd8);

    $display("[TB] misaligned start");
    apply_stimulus(1'b0, 1'b1);
    start_segment();
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    repeat (4) send_byte(COMMA);
    send_byte(8'hA7);
    check_eq("misalign_count", 32'(dut_q.size()), 32'd1);
    check_eq("misalign_byte", 32'(dut_q[0]), 32'hA7);

    $display("[TB] aborted alignment");
    apply_stimulus(1'b0, 1'b1);
    start_segment();
    repeat (3) send_byte(COMMA);
    send_byte(8'h12);
    check_eq("abort_active", 32'(active), 32'h0);
    repeat (3) send_byte(COMMA);
    check_eq("abort_not_yet", 32'(active), 32'h0);
    send_byte(COMMA);
    send_byte(8'h66);
    check_eq("abort_count", 32'(dut_q.size()), 32'd1);
    check_eq("abort_byte", 32'(dut_q[0]), 32'h66);

    $display("[TB] straddling false comma");
    apply_stimulus(1'b0, 1'b1);
    start_segment();
    send_byte(8'h0B);
    send_byte(8'hC0);
    send_byte(COMMA);
    send_byte(COMMA);
    check_eq("straddle_no_early", 32'(active), 32'h0);
    send_byte(COMMA);
    send_byte(COMMA);
    check_eq("straddle_locked", 32'(active), 32'h1);
    send_byte(8'h5E);
    check_eq("straddle_count", 32'(dut_q.size()), 32'd1);
    check_eq("straddle_byte", 32'(dut_q[0]), 32'h5E);

    $display("[TB] reset in the middle of a byte while active");
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    check_eq("midreset_data", 32'(data_outP), 32'h00);
    check_eq("midreset_valid", 32'(valid_out), 32'h0);
    check_eq("midreset_strobe", 32'(byte_strobe), 32'h0);
    check_eq("midreset_active", 32'(active), 32'h0);
    start_segment();
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    repeat (3) send_byte(8'h00);
    check_eq("midreset_no_valid", 32'(dut_q.size()), 32'd0);
    repeat (4) send_byte(COMMA);
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_byte(rb);
    end
    compare_queues("midreset_data_seq");

    $display("[TB] random traffic trials");
    for (int t = 0; t < 3; t++) begin
      apply_stimulus(1'b0, 1'b1);
      start_segment();
      n = int'($urandom_range(0, 20));
      for (int i = 0; i < n; i++) apply_stimulus(1'($urandom_range(0, 1)), 1'b0);
      repeat (4) send_byte(COMMA);
      for (int i = 0; i < 12; i++) begin
        rb = ($urandom_range(0, 3) == 0) ? COMMA : 8'($urandom_range(0, 255));
        send_byte(rb);
      end
      compare_queues("random_trial");
    end

    $display("[TB] free-running random bits");
    start_segment();
    for (int i = 0; i < 200; i++) apply_stimulus(1'($urandom_range(0, 1)), 1'b0);
    compare_queues("random_bits");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
